// File: rtl/acc_load_sequencer.sv
// acc_load_sequencer: accumulator control for the IL pipelined processor.
// Drives the accumulator-mux select, owns the accumulator register,
// sequences multi-cycle ALU loads and keeps the IL parenthesis nesting
// stack ("OP(" pushes the accumulator, ")" pops it as ALU operand B).
// Optional feature macro: ACC_FLAGS_EN adds registered acc_zero/acc_neg
// flags, updated on every accumulator load.
module acc_load_sequencer #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int ALU_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           op_valid,
    output logic                           op_ready,
    input  logic [2:0]                     op_code,
    input  logic [DATA_W-1:0]              imm_data,
    output logic [1:0]                     acc_mux_sel,
    input  logic [DATA_W-1:0]              acc_mux_out,
    output logic                           alu_start,
    output logic                           alu_b_sel,
    output logic [DATA_W-1:0]              stack_top,
    output logic [DATA_W-1:0]              acc_q,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           err_ovf,
    output logic                           err_unf,
    input  logic                           clr_err
`ifdef ACC_FLAGS_EN
    ,
    output logic                           acc_zero,
    output logic                           acc_neg
`endif
);

    localparam int IDX_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = IDX_W + 1;

    localparam logic [2:0] OP_LD_IMM   = 3'b001;
    localparam logic [2:0] OP_ALU      = 3'b010;
    localparam logic [2:0] OP_PUSH_IMM = 3'b011;
    localparam logic [2:0] OP_POP_ALU  = 3'b100;

    localparam logic [1:0] SEL_IMM  = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_IDLE = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              stateReg, stateNext;
    logic [2:0]          cntReg, cntNext;
    logic                popOpReg, popOpNext;
    logic [DATA_W-1:0]   accReg;
    logic [DEPTH_W-1:0]  depthReg;
    logic                errOvfReg, errUnfReg;
    logic [DATA_W-1:0]   stackReg [STACK_DEPTH];

    logic                accept;
    logic                loadAcc;
    logic                doPush;
    logic                doPop;
    logic                setOvf;
    logic                setUnf;
    logic                stackEmpty;
    logic                stackFull;
    logic [IDX_W-1:0]    topIdx;

    // The immediate reaches the accumulator only through the external mux.
    logic                unusedImm;
    assign unusedImm = ^imm_data;

    assign stackEmpty = (depthReg == '0);
    assign stackFull  = (depthReg == DEPTH_W'(STACK_DEPTH));
    // Low bits of depth minus one wrap correctly when the stack is full.
    assign topIdx     = depthReg[IDX_W-1:0] - IDX_W'(1);
    assign accept     = op_valid && (stateReg == IDLE);

    // Next-state, mux select and ALU handshake decode.
    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        popOpNext   = popOpReg;
        acc_mux_sel = SEL_IDLE;
        alu_start   = 1'b0;
        alu_b_sel   = 1'b0;
        loadAcc     = 1'b0;
        doPush      = 1'b0;
        doPop       = 1'b0;
        setOvf      = 1'b0;
        setUnf      = 1'b0;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_LD_IMM: begin
                            acc_mux_sel = SEL_IMM;
                            loadAcc     = 1'b1;
                        end
                        OP_ALU: begin
                            alu_start = 1'b1;
                            stateNext = WAIT;
                            cntNext   = 3'(ALU_LAT);
                            popOpNext = 1'b0;
                        end
                        OP_PUSH_IMM: begin
                            if (stackFull) begin
                                setOvf = 1'b1;
                            end else begin
                                doPush      = 1'b1;
                                acc_mux_sel = SEL_IMM;
                                loadAcc     = 1'b1;
                            end
                        end
                        OP_POP_ALU: begin
                            if (stackEmpty) begin
                                setUnf = 1'b1;
                            end else begin
                                alu_start = 1'b1;
                                alu_b_sel = 1'b1;
                                stateNext = WAIT;
                                cntNext   = 3'(ALU_LAT);
                                popOpNext = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                // B stays on stack_top for the whole pop, including the load cycle.
                alu_b_sel = popOpReg;
                if (cntReg == 3'd1) begin
                    acc_mux_sel = SEL_ALU;
                    loadAcc     = 1'b1;
                    doPop       = popOpReg;
                    stateNext   = IDLE;
                end else begin
                    cntNext = cntReg - 3'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Control state, accumulator, depth and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            cntReg    <= '0;
            popOpReg  <= 1'b0;
            accReg    <= '0;
            depthReg  <= '0;
            errOvfReg <= 1'b0;
            errUnfReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            popOpReg <= popOpNext;
            if (loadAcc) accReg <= acc_mux_out;
            if (doPush) depthReg <= depthReg + DEPTH_W'(1);
            else if (doPop) depthReg <= depthReg - DEPTH_W'(1);
            // A new error wins over a coincident clear.
            if (setOvf) errOvfReg <= 1'b1;
            else if (clr_err) errOvfReg <= 1'b0;
            if (setUnf) errUnfReg <= 1'b1;
            else if (clr_err) errUnfReg <= 1'b0;
        end
    end

    // One register per stack entry: written on push, zeroed when popped.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : gStack
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stackReg[gi] <= '0;
                end else if (doPush && depthReg == DEPTH_W'(gi)) begin
                    stackReg[gi] <= accReg;
                end else if (doPop && topIdx == IDX_W'(gi)) begin
                    stackReg[gi] <= '0;
                end
            end
        end
    endgenerate

`ifdef ACC_FLAGS_EN
    logic accZeroReg, accNegReg;

    // Flags track the value written into the accumulator at each load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accZeroReg <= 1'b1;
            accNegReg  <= 1'b0;
        end else if (loadAcc) begin
            accZeroReg <= (acc_mux_out == '0);
            accNegReg  <= acc_mux_out[DATA_W-1];
        end
    end

    assign acc_zero = accZeroReg;
    assign acc_neg  = accNegReg;
`endif

    assign op_ready  = (stateReg == IDLE);
    assign acc_q     = accReg;
    assign depth     = depthReg;
    assign err_ovf   = errOvfReg;
    assign err_unf   = errUnfReg;
    assign stack_top = stackEmpty ? '0 : stackReg[topIdx];

endmodule

// File: doc/acc_load_sequencer.md
Name: acc_load_sequencer

Overview:
- Controls the accumulator of the IL pipelined processor: drives the accumulator-mux select, owns the accumulator register, and sequences multi-cycle ALU loads.
- Implements the IL parenthesis nesting stack. "OP(" pushes the accumulator; ")" pops it as the ALU B operand.
- Sits between the decode stage, the ALU and the accumulator mux.

Parameters:
DATA_W, 8, accumulator/immediate/ALU data width
STACK_DEPTH, 4, nesting stack entries (power of 2, >=2)
ALU_LAT, 1, ALU result latency in cycles after alu_start (1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
op_valid  in  1  decode presents an accumulator op
op_ready  out  1  sequencer can accept an op this cycle
op_code  in  3  000 NOP, 001 LD_IMM, 010 ALU, 011 PUSH_IMM, 100 POP_ALU, others treated as NOP
imm_data  in  DATA_W  immediate operand
acc_mux_sel  out  2  00 immediate, 01 ALU result, 10 idle (mux output undriven; never loaded)
acc_mux_out  in  DATA_W  accumulator-mux output
alu_start  out  1  one-cycle pulse launching an ALU operation
alu_b_sel  out  1  0 = B from memory path, 1 = B from stack_top
stack_top  out  DATA_W  top stack entry (0 when empty)
acc_q  out  DATA_W  accumulator register
depth  out  $clog2(STACK_DEPTH)+1  current stack occupancy
err_ovf  out  1  sticky push-on-full error
err_unf  out  1  sticky pop-on-empty error
clr_err  in  1  clears both error flags

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, acc_q=0, depth=0, all stack entries 0.
  - acc_mux_sel=10, op_ready=1, alu_start=0, alu_b_sel=0, err_ovf=err_unf=0.
- FSM states IDLE, WAIT (ALU_LAT-cycle countdown). op_ready=1 only in IDLE.
- Accept = op_valid & op_ready. With no accept, acc_mux_sel=10 and acc_q holds.
- LD_IMM: in the accept cycle acc_mux_sel=00; acc_q<=acc_mux_out at that edge. Stays IDLE, zero bubbles.
- ALU op:
  - In the accept cycle: alu_start=1, alu_b_sel=0; go to WAIT with cnt=ALU_LAT.
  - In WAIT, cnt decrements each cycle. In the cycle with cnt==1: acc_mux_sel=01, acc_q<=acc_mux_out, return to IDLE.
  - ALU_LAT=1: accept at T, load at end of T+1, op_ready high again at T+2.
- PUSH_IMM:
  - If depth<STACK_DEPTH: stack[depth]<=acc_q, depth+1, acc_mux_sel=00, acc_q<=acc_mux_out. All in one cycle.
  - If depth==STACK_DEPTH: err_ovf<=1; stack, depth and acc_q unchanged; op consumed.
- POP_ALU:
  - If depth>0: alu_start=1; alu_b_sel=1 from the accept cycle through the load cycle; stack_top stays valid throughout. Then WAIT exactly as for an ALU op. In the load cycle, depth-1 and that entry cleared to 0.
  - If depth==0: err_unf<=1, no alu_start, op consumed, stays IDLE.
- stack_top = stack[depth-1], or 0 when depth==0. Combinational from registers.
- Errors: sticky until clr_err. If a new error and clr_err occur in the same cycle, the set wins for that flag.
- Ops presented while op_ready=0 are ignored; decode must hold op_valid.
- Reset during WAIT aborts the op: no load, stack cleared.
- acc_mux_sel is never 00 or 01 except in a cycle where acc_q loads.

Optional Feature:
ACC_FLAGS_EN
- Defined: adds outputs acc_zero and acc_neg, registered, updated on every acc_q load:
  - acc_zero = (new value == 0).
  - acc_neg = new value MSB.
  - Both reset to acc_zero=1, acc_neg=0.
- Undefined: ports absent, no flag logic.

Test Plan:
- Reset released, LD_IMM imm=8'h3C -> acc_mux_sel=00 in the accept cycle; acc_q=8'h3C next cycle; op_ready never drops.
- ALU op with ALU_LAT=1, ALU returns 8'h55 -> alu_start pulse at T; op_ready=0 and acc_mux_sel=01 at T+1; acc_q=8'h55 at T+2; op_ready=1 at T+2.
- acc_q=8'h11, PUSH_IMM imm=8'h22, then POP_ALU with ALU returning 8'h33:
  - After the push: depth=1, stack_top=8'h11, acc_q=8'h22.
  - During the pop: alu_b_sel=1.
  - After the pop: depth=0, acc_q=8'h33.
- Five PUSH_IMM with STACK_DEPTH=4 -> depth stops at 4; err_ovf=1 after the fifth; acc_q holds the fourth immediate. Then clr_err -> err_ovf=0.
- POP_ALU at depth=0 -> err_unf=1, no alu_start, acc_q unchanged. clr_err coincident with a second empty POP_ALU -> err_unf stays 1.
- rst_n asserted mid-WAIT of a POP_ALU at depth=2 -> immediately depth=0, acc_q=0, op_ready=1, acc_mux_sel=10; no load after release.
